// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style acknowledge sequencer.
//   pic_state_e     : acknowledge FSM states
//   SPURIOUS_LEVEL  : level reported when the request vanishes before ACK1
//   encode_onehot() : one-hot resolver winner -> 3-bit level
//   level_mask()    : 3-bit level -> one-hot bit mask
package pic_pkg;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned LVL_W = 3;

  localparam logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } pic_state_e;

  // OR of set-bit indices; exact for a one-hot input.
  function automatic logic [LVL_W-1:0] encode_onehot(input logic [IR_W-1:0] onehot);
    logic [LVL_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < IR_W; i++) begin
      if (onehot[i]) lvl = lvl | LVL_W'(i);
    end
    return lvl;
  endfunction

  function automatic logic [IR_W-1:0] level_mask(input logic [LVL_W-1:0] lvl);
    return IR_W'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_isr_highest.sv
// Rotated priority scan of the in-service register.
//   isr_i       : in-service register
//   base_i      : rotation base (highest-priority level)
//   level_c_o   : first set level scanning base_i, base_i+1, ... mod 8
//   found_c_o   : 1 when any ISR bit is set
module pic_isr_highest
  import pic_pkg::*;
(
  input  logic [IR_W-1:0]  isr_i,
  input  logic [LVL_W-1:0] base_i,
  output logic [LVL_W-1:0] level_c_o,
  output logic             found_c_o
);

  logic [LVL_W-1:0] idx;

  // First hit in rotated order wins; 3-bit add wraps naturally.
  always_comb begin
    level_c_o = '0;
    found_c_o = 1'b0;
    idx       = '0;
    for (int i = 0; i < IR_W; i++) begin
      idx = base_i + LVL_W'(i);
      if (!found_c_o && isr_i[idx]) begin
        level_c_o = idx;
        found_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259-style interrupt acknowledge sequencer (8086 two-INTA mode).
// Owns INT, the ISR, the rotation base and the resolver freeze; services
// EOI / set-priority commands and drives the vector byte on the second INTA.
// Optional build macro PIC_SPECIAL_FULLY_NESTED_EN adds sfnm_mode: INT is
// also raised for a winner already in service (cascade slave re-request).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   interrupt           : one-hot resolver winner (0 = none)
//   inta_n              : acknowledge strobe, active low, clk-synchronous
//   vector_base         : T7..T3 of the vector
//   eoi_*               : EOI command strobe and qualifiers
//   set_prio_valid      : make eoi_level lowest priority
//   aeoi_mode/rotate    : auto-EOI controls
//   int_out, freeze, clear_request, in_service_register, priority_rotate,
//   data_out, data_out_en : registered outputs
module pic_ack_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IR_W-1:0]   interrupt,
`ifdef PIC_SPECIAL_FULLY_NESTED_EN
  input  logic              sfnm_mode,
`endif
  input  logic              inta_n,
  input  logic [4:0]        vector_base,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic              eoi_rotate,
  input  logic [LVL_W-1:0]  eoi_level,
  input  logic              set_prio_valid,
  input  logic              aeoi_mode,
  input  logic              aeoi_rotate,
  output logic              int_out,
  output logic              freeze,
  output logic [IR_W-1:0]   clear_request,
  output logic [IR_W-1:0]   in_service_register,
  output logic [LVL_W-1:0]  priority_rotate,
  output logic [7:0]        data_out,
  output logic              data_out_en
);

  pic_state_e       state_q, state_d;
  logic             inta_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             spurious_q, spurious_d;
  logic             int_out_q, int_out_d;
  logic             freeze_q, freeze_d;
  logic [IR_W-1:0]  clr_q, clr_d;
  logic [IR_W-1:0]  isr_q, isr_d;
  logic [LVL_W-1:0] prio_q, prio_d;
  logic [7:0]       dout_q, dout_d;
  logic             den_q, den_d;

  logic             fall_c, rise_c;
  logic             irq_any_c;
  logic [LVL_W-1:0] hi_level_c;
  logic             hi_found_c;
  logic [LVL_W-1:0] eoi_tgt_c;
  logic             eoi_hit_c;
  logic [IR_W-1:0]  set_mask_c, clr_mask_c;
  logic [LVL_W-1:0] win_level_c;

  assign fall_c = inta_q & ~inta_n;
  assign rise_c = ~inta_q & inta_n;

`ifdef PIC_SPECIAL_FULLY_NESTED_EN
  // Winners already in service only count as a request in SFNM.
  assign irq_any_c = (|(interrupt & ~isr_q)) | (sfnm_mode & (|(interrupt & isr_q)));
`else
  assign irq_any_c = |interrupt;
`endif

  assign win_level_c = encode_onehot(interrupt);

  // Highest-priority in-service level for non-specific EOI.
  pic_isr_highest u_isr_highest (
    .isr_i     (isr_q),
    .base_i    (prio_q),
    .level_c_o (hi_level_c),
    .found_c_o (hi_found_c)
  );

  assign eoi_tgt_c = eoi_specific ? eoi_level : hi_level_c;
  assign eoi_hit_c = eoi_valid & (eoi_specific | hi_found_c);

  // Acknowledge FSM, ISR and rotation next-state.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    int_out_d  = 1'b0;
    freeze_d   = freeze_q;
    clr_d      = '0;
    isr_d      = isr_q;
    prio_d     = prio_q;
    dout_d     = dout_q;
    den_d      = 1'b0;
    set_mask_c = '0;
    clr_mask_c = '0;

    case (state_q)
      IDLE: begin
        int_out_d = irq_any_c;
        if (fall_c) begin
          state_d   = ACK1;
          freeze_d  = 1'b1;
          int_out_d = 1'b0;
          if (interrupt == '0) begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end else begin
            level_d    = win_level_c;
            spurious_d = 1'b0;
            set_mask_c = level_mask(win_level_c);
            clr_d      = level_mask(win_level_c);
          end
        end
      end
      ACK1: begin
        if (rise_c) state_d = WAIT2;
      end
      WAIT2: begin
        if (fall_c) begin
          state_d = ACK2;
          dout_d  = {vector_base, level_q};
          den_d   = 1'b1;
        end
      end
      ACK2: begin
        dout_d = {vector_base, level_q};
        if (rise_c) begin
          state_d  = IDLE;
          freeze_d = 1'b0;
          if (aeoi_mode && !spurious_q) begin
            clr_mask_c = level_mask(level_q);
            if (aeoi_rotate) prio_d = level_q + 3'd1;
          end
        end else begin
          den_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (eoi_hit_c) begin
      clr_mask_c = clr_mask_c | level_mask(eoi_tgt_c);
      if (eoi_rotate) prio_d = eoi_tgt_c + 3'd1;
    end

    if (set_prio_valid) prio_d = eoi_level + 3'd1;

    // Clear before set: a same-cycle EOI and ACK1 on one bit leaves it set.
    isr_d = (isr_q & ~clr_mask_c) | set_mask_c;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inta_q     <= 1'b1;
      level_q    <= '0;
      spurious_q <= 1'b0;
      int_out_q  <= 1'b0;
      freeze_q   <= 1'b0;
      clr_q      <= '0;
      isr_q      <= '0;
      prio_q     <= '0;
      dout_q     <= '0;
      den_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_n;
      level_q    <= level_d;
      spurious_q <= spurious_d;
      int_out_q  <= int_out_d;
      freeze_q   <= freeze_d;
      clr_q      <= clr_d;
      isr_q      <= isr_d;
      prio_q     <= prio_d;
      dout_q     <= dout_d;
      den_q      <= den_d;
    end
  end

  assign int_out             = int_out_q;
  assign freeze              = freeze_q;
  assign clear_request       = clr_q;
  assign in_service_register = isr_q;
  assign priority_rotate     = prio_q;
  assign data_out            = dout_q;
  assign data_out_en         = den_q;

endmodule

// File: doc/pic_ack_sequencer.md
Name: pic_ack_sequencer

Overview:
- Sequences the 8259-style interrupt acknowledge cycle around the priority resolver.
- Raises INT when the resolver reports a winner, then handles the two INTA pulses (8086 mode).
- Owns the in-service register (ISR), the rotation base and the resolver freeze.
- Services EOI / set-priority commands from control logic and drives the interrupt vector onto the data bus.

Parameters:
- NUM_IR, 8, number of interrupt lines. Fixed; the rotate arithmetic is 3-bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- interrupt  in  8  one-hot winner from the priority resolver, 0 if none
- inta_n  in  1  interrupt acknowledge, active low, synchronous to clk
- vector_base  in  5  T7..T3 from ICW2
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI using eoi_level
- eoi_rotate  in  1  1 = rotate priority on this EOI
- eoi_level  in  3  level for a specific EOI
- set_prio_valid  in  1  strobe: make eoi_level the lowest priority, without EOI
- aeoi_mode  in  1  auto-EOI enable from ICW4
- aeoi_rotate  in  1  rotate on auto-EOI
- int_out  out  1  INT pin to the CPU
- freeze  out  1  holds the resolver's request sampling
- clear_request  out  8  one-cycle pulse that clears the acknowledged IRR bit
- in_service_register  out  8  ISR
- priority_rotate  out  3  rotation base to the resolver
- data_out  out  8  vector byte
- data_out_en  out  1  data bus drive enable

Behaviour:
- Reset, asynchronous: every register clears, FSM enters IDLE. All outputs reset to 0: int_out, freeze, clear_request, ISR, priority_rotate, data_out, data_out_en.
- Edge detect: inta_n is registered. A falling edge is `prev=1 & cur=0`; a rising edge is `prev=0 & cur=1`. The edge register resets to 1.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
- IDLE:
  - int_out = |interrupt, registered (1-cycle latency).
  - On an INTA falling edge, go to ACK1.
- ACK1 entry cycle:
  - Set freeze = 1.
  - Latch `level` = encoded interrupt.
  - If interrupt == 0 (request withdrawn), latch level 7 as spurious: no ISR set, no clear_request.
  - Otherwise set ISR[level] and pulse clear_request[level] for one cycle.
  - Drop int_out.
  - Go to WAIT2 on the INTA rising edge.
- WAIT2: on the next INTA falling edge, go to ACK2.
- ACK2:
  - data_out = {vector_base, level}; data_out_en = 1 while inta_n is low.
  - On the INTA rising edge:
    - data_out_en = 0 and freeze = 0.
    - If aeoi_mode and the interrupt was not spurious, clear ISR[level]. If aeoi_rotate is also set, priority_rotate = level + 1 (mod 8).
    - Go to IDLE.
- EOI, accepted in any state, applied in the strobe cycle:
  - Non-specific EOI clears the highest-priority set ISR bit: scan bits priority_rotate, +1, ... wrapping mod 8; the first set bit is the target.
  - Specific EOI targets eoi_level.
  - If eoi_rotate, priority_rotate = target + 1 (mod 8).
  - A non-specific EOI with ISR == 0 does nothing; priority_rotate is unchanged even if eoi_rotate is set.
- set_prio_valid: priority_rotate = eoi_level + 1 (mod 8). If it coincides with an EOI rotate, set_prio_valid wins.
- Same-cycle ISR clear (EOI) and set (ACK1): the clear is applied first, then the set. If both hit the same bit, the bit ends up set.
- A falling INTA edge in WAIT2 or ACK2 with no prior rising edge cannot occur (edges alternate); no check is required.
- Reset mid-acknowledge aborts to IDLE with ISR cleared.

Optional Feature:
- Macro: PIC_SPECIAL_FULLY_NESTED_EN.
- Defined: adds input `sfnm_mode` (1 bit). When set, int_out is also raised when the resolver's winner equals a level already in ISR (cascade slave re-request). ACK1 does not double-set the ISR bit; it is already set.
- Undefined: no sfnm_mode port. int_out ignores ISR, since the resolver already masks by ISR.

Decomposition:
- Package pic_pkg holds:
  - the FSM state enum (IDLE/ACK1/WAIT2/ACK2);
  - constants SPURIOUS_LEVEL = 3'd7 and IR_W = 8;
  - a one-hot-to-binary encode function.
- One sub-module, pic_isr_highest: combinational rotated scan of the ISR that returns the highest-priority level plus a found flag. It is used for the non-specific EOI.

Test Plan:
- Basic acknowledge:
  - Stimulus: interrupt = 8'h08, vector_base = 5'h10, two INTA pulses.
  - Response: int_out = 1; ISR = 8'h08 after the first pulse; clear_request = 8'h08 for one cycle; data_out = 8'h83 during the second pulse; freeze falls after it.
- Spurious request:
  - Stimulus: interrupt drops to 0 before the first INTA falling edge.
  - Response: ISR stays 0; no clear_request; data_out = {base, 3'd7}.
- Non-specific EOI under rotation:
  - Stimulus: ISR = 8'h41, priority_rotate = 3; eoi_valid with eoi_specific = 0, eoi_rotate = 1.
  - Response: ISR = 8'h01; priority_rotate = 7.
- Auto-EOI:
  - Stimulus: aeoi_mode = 1, aeoi_rotate = 1, acknowledge of IR2.
  - Response: ISR returns to 0 on the second INTA rising edge; priority_rotate = 3.
- Collision:
  - Stimulus: specific EOI for level 5 in the same cycle as ACK1 for IR5.
  - Response: ISR[5] = 1.
- Async reset mid-acknowledge:
  - Stimulus: rst_n low during WAIT2.
  - Response: all outputs 0 immediately; FSM in IDLE.
